// File: rtl/phase_pkg.sv
// Shared types and constants for the phase generator: FSM state encoding,
// default counter width and the smallest period that can form a square wave.
package phase_pkg;

    localparam int W_DEF      = 16;
    localparam int MIN_PERIOD = 2;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/phase_gen_cfg.sv
// Configuration path for phase_gen: valid/ready intake, legality check,
// a one-deep shadow register and the active register the waves run from.
module phase_gen_cfg
    import phase_pkg::*;
#(
    parameter int W = W_DEF
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         cfg_valid,
    output logic         cfg_ready,
    input  logic [W-1:0] cfg_period,
    input  logic [W-1:0] cfg_shift,
    input  logic         apply_ok,
    output logic         cfg_err,
    output logic         act_valid,
    output logic [W-1:0] period_act,
    output logic [W-1:0] shift_act
);

    // Handshake: a config transfers on a rising edge where cfg_valid and
    // cfg_ready are both 1; cfg_ready depends only on registered state, and
    // the offer may be held or withdrawn freely while cfg_ready is 0.

    logic         shadow_valid;
    logic [W-1:0] shadow_period;
    logic [W-1:0] shadow_shift;
    logic         accept;
    logic         legal;
    logic         apply;

    assign cfg_ready = !shadow_valid;
    assign accept    = cfg_valid && cfg_ready;
    assign legal     = (cfg_period >= W'(MIN_PERIOD)) && (cfg_shift < cfg_period);

    // Accept needs an empty shadow and apply needs a full one, so the two
    // never collide on the same edge.
    assign apply     = shadow_valid && apply_ok;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_valid  <= 1'b0;
            shadow_period <= '0;
            shadow_shift  <= '0;
            act_valid     <= 1'b0;
            period_act    <= '0;
            shift_act     <= '0;
            cfg_err       <= 1'b0;
        end else begin
            cfg_err <= accept && !legal;
            if (apply) begin
                period_act   <= shadow_period;
                shift_act    <= shadow_shift;
                act_valid    <= 1'b1;
                shadow_valid <= 1'b0;
            end else if (accept && legal) begin
                shadow_period <= cfg_period;
                shadow_shift  <= cfg_shift;
                shadow_valid  <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/phase_gen.sv
// Two-phase square wave generator: fx1 reference, fx2 lagging by a configured
// shift. Optional saturating period counter output under PHASE_GEN_CNT_EN.
module phase_gen
    import phase_pkg::*;
#(
    parameter int W = W_DEF
) (
    input  logic         sys_clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic         cfg_valid,
    output logic         cfg_ready,
    input  logic [W-1:0] cfg_period,
    input  logic [W-1:0] cfg_shift,
    output logic         fx1,
    output logic         fx2,
    output logic         period_end_flag,
    output logic         cfg_err,
    output logic         dbg_state
`ifdef PHASE_GEN_CNT_EN
    ,
    output logic [W-1:0] period_cnt
`endif
);

    state_t       state;
    state_t       state_nxt;
    logic [W-1:0] cnt;
    logic [W-1:0] cnt_nxt;
    logic         act_valid;
    logic [W-1:0] period_act;
    logic [W-1:0] shift_act;
    logic [W-1:0] half;
    logic [W:0]   lag_pos;
    logic         wrap;
    logic         apply_ok;
    logic         fx1_nxt;
    logic         fx2_nxt;

    phase_gen_cfg #(
        .W (W)
    ) u_cfg (
        .clk        (sys_clk),
        .rst_n      (rst_n),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_period (cfg_period),
        .cfg_shift  (cfg_shift),
        .apply_ok   (apply_ok),
        .cfg_err    (cfg_err),
        .act_valid  (act_valid),
        .period_act (period_act),
        .shift_act  (shift_act)
    );

    assign half      = period_act >> 1;
    assign wrap      = (state == RUN) && (cnt == period_act - W'(1));
    assign apply_ok  = (state == IDLE) || wrap;
    assign dbg_state = (state == RUN);

    // Position of fx2 within its own period; one extra bit keeps the
    // cnt + period sum from overflowing.
    always_comb begin
        lag_pos = '0;
        if (cnt >= shift_act) begin
            lag_pos = {1'b0, cnt} - {1'b0, shift_act};
        end else begin
            lag_pos = {1'b0, cnt} + {1'b0, period_act} - {1'b0, shift_act};
        end
    end

    assign fx1_nxt = (state == RUN) && (cnt < half);
    assign fx2_nxt = (state == RUN) && (lag_pos < {1'b0, half});

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                cnt_nxt = '0;
                if (en && act_valid) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (wrap) begin
                    cnt_nxt = '0;
                    if (!en) begin
                        state_nxt = IDLE;
                    end
                end else begin
                    cnt_nxt = cnt + W'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            cnt             <= '0;
            fx1             <= 1'b0;
            fx2             <= 1'b0;
            period_end_flag <= 1'b0;
        end else begin
            state           <= state_nxt;
            cnt             <= cnt_nxt;
            fx1             <= fx1_nxt;
            fx2             <= fx2_nxt;
            period_end_flag <= wrap;
        end
    end

`ifdef PHASE_GEN_CNT_EN
    // Advances on the same edge that raises period_end_flag.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            period_cnt <= '0;
        end else if (wrap && (period_cnt != '1)) begin
            period_cnt <= period_cnt + W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_phase_gen.sv
// Randomized bench for phase_gen with an integer phase model and a few
// literal waveform expectations.
module tb_phase_gen;

    localparam int W = 16;

    logic         sys_clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         en = 1'b0;
    logic         cfg_valid = 1'b0;
    logic [W-1:0] cfg_period = '0;
    logic [W-1:0] cfg_shift = '0;
    logic         cfg_ready;
    logic         fx1;
    logic         fx2;
    logic         period_end_flag;
    logic         cfg_err;
    logic         dbg_state;
`ifdef PHASE_GEN_CNT_EN
    logic [W-1:0] period_cnt;
`endif

    int checks = 0;
    int failures = 0;
    bit chk_on = 1'b0;

    phase_gen #(.W(W)) dut (
        .sys_clk         (sys_clk),
        .rst_n           (rst_n),
        .en              (en),
        .cfg_valid       (cfg_valid),
        .cfg_ready       (cfg_ready),
        .cfg_period      (cfg_period),
        .cfg_shift       (cfg_shift),
        .fx1             (fx1),
        .fx2             (fx2),
        .period_end_flag (period_end_flag),
        .cfg_err         (cfg_err),
        .dbg_state       (dbg_state)
`ifdef PHASE_GEN_CNT_EN
        ,
        .period_cnt      (period_cnt)
`endif
    );

    always #5 sys_clk = ~sys_clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: position within the running period, active/pending configs.
    int m_pos = 0, m_p = 0, m_s = 0, m_shp = 0, m_shs = 0;
    bit m_run = 0, m_act = 0, m_sh = 0;
    bit e_fx1 = 0, e_fx2 = 0, e_pef = 0, e_err = 0;
    int e_pcnt = 0;
    bit t_acc, t_legal, t_wrap, t_apply;

    always @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pos = 0; m_p = 0; m_s = 0; m_run = 0; m_act = 0; m_sh = 0;
            e_fx1 = 0; e_fx2 = 0; e_pef = 0; e_err = 0; e_pcnt = 0;
        end else begin
            t_acc   = cfg_valid && !m_sh;
            t_legal = (int'(cfg_period) >= 2) && (int'(cfg_shift) < int'(cfg_period));
            t_wrap  = m_run && (m_pos == m_p - 1);
            t_apply = m_sh && (!m_run || t_wrap);
            e_fx1 = m_run && (m_pos < m_p / 2);
            e_fx2 = m_run && (((m_pos - m_s + m_p) % m_p) < m_p / 2);
            e_pef = t_wrap;
            e_err = t_acc && !t_legal;
            if (t_wrap && e_pcnt < 65535) e_pcnt = e_pcnt + 1;
            if (!m_run) begin
                m_run = en && m_act;
                m_pos = 0;
            end else if (t_wrap) begin
                m_pos = 0;
                m_run = en;
            end else begin
                m_pos = m_pos + 1;
            end
            if (t_apply) begin
                m_p = m_shp; m_s = m_shs; m_act = 1; m_sh = 0;
            end else if (t_acc && t_legal) begin
                m_shp = int'(cfg_period); m_shs = int'(cfg_shift); m_sh = 1;
            end
        end
    end

    always @(negedge sys_clk) begin
        if (chk_on) begin
            check("fx1", 32'(fx1), 32'(e_fx1));
            check("fx2", 32'(fx2), 32'(e_fx2));
            check("period_end_flag", 32'(period_end_flag), 32'(e_pef));
            check("cfg_err", 32'(cfg_err), 32'(e_err));
            check("cfg_ready", 32'(cfg_ready), 32'(!m_sh));
            check("dbg_state", 32'(dbg_state), 32'(m_run));
`ifdef PHASE_GEN_CNT_EN
            check("period_cnt", 32'(period_cnt), 32'(e_pcnt));
`endif
        end
    end

    task automatic send_cfg(input int p, input int s);
        @(negedge sys_clk);
        cfg_valid  = 1'b1;
        cfg_period = W'(p);
        cfg_shift  = W'(s);
        @(negedge sys_clk);
        cfg_valid  = 1'b0;
    endtask

    task automatic wait_pef(input string name);
        bit found = 0;
        for (int i = 0; i < 64 && !found; i++) begin
            @(negedge sys_clk);
            if (period_end_flag) found = 1;
        end
        check(name, 32'(found), 32'd1);
    endtask

    task automatic wait_ready(input string name);
        bit found = 0;
        for (int i = 0; i < 64 && !found; i++) begin
            @(negedge sys_clk);
            if (cfg_ready) found = 1;
        end
        check(name, 32'(found), 32'd1);
    endtask

    logic [7:0]  s8a, s8b;
    logic [11:0] s12a, s12b;
    logic [6:0]  s7a, s7b;

    initial begin
        repeat (3) @(negedge sys_clk);
        check("rst_fx1", 32'(fx1), 32'd0);
        check("rst_fx2", 32'(fx2), 32'd0);
        check("rst_pef", 32'(period_end_flag), 32'd0);
        check("rst_err", 32'(cfg_err), 32'd0);
        check("rst_ready", 32'(cfg_ready), 32'd1);
        check("rst_state", 32'(dbg_state), 32'd0);
        chk_on = 1'b1;
        #1 rst_n = 1'b1;

        // period 8, shift 2
        en = 1'b1;
        send_cfg(8, 2);
        check("p8_ready_low", 32'(cfg_ready), 32'd0);
        wait_pef("p8_first_pef");
        for (int i = 0; i < 8; i++) begin
            @(negedge sys_clk);
            s8a = {s8a[6:0], fx1};
            s8b = {s8b[6:0], fx2};
        end
        check("p8_fx1_pattern", 32'(s8a), 32'h0F0);
        check("p8_fx2_pattern", 32'(s8b), 32'h03C);
        check("p8_pef_period", 32'(period_end_flag), 32'd1);

        // rejected configs
        send_cfg(1, 0);
        check("err_p1_pulse", 32'(cfg_err), 32'd1);
        @(negedge sys_clk);
        check("err_p1_clear", 32'(cfg_err), 32'd0);
        check("err_p1_ready", 32'(cfg_ready), 32'd1);
        send_cfg(10, 10);
        check("err_s10_pulse", 32'(cfg_err), 32'd1);
        @(negedge sys_clk);
        check("err_s10_clear", 32'(cfg_err), 32'd0);

        // mid-period reload to 12/3
        send_cfg(12, 3);
        check("p12_ready_low", 32'(cfg_ready), 32'd0);
        wait_ready("p12_apply");
        check("p12_pef_at_apply", 32'(period_end_flag), 32'd1);
        for (int i = 0; i < 12; i++) begin
            @(negedge sys_clk);
            s12a = {s12a[10:0], fx1};
            s12b = {s12b[10:0], fx2};
        end
        check("p12_fx1_pattern", 32'(s12a), 32'hFC0);
        check("p12_fx2_pattern", 32'(s12b), 32'h1F8);
        check("p12_pef_period", 32'(period_end_flag), 32'd1);

        // odd period 7, no shift
        send_cfg(7, 0);
        wait_ready("p7_apply");
        for (int i = 0; i < 7; i++) begin
            @(negedge sys_clk);
            s7a = {s7a[5:0], fx1};
            s7b = {s7b[5:0], fx2};
        end
        check("p7_fx1_pattern", 32'(s7a), 32'h70);
        check("p7_fx2_pattern", 32'(s7b), 32'h70);

        // en dropped at cnt=3 of period 8
        send_cfg(8, 2);
        wait_ready("p8b_apply");
        repeat (3) @(negedge sys_clk);
        en = 1'b0;
        repeat (6) @(negedge sys_clk);
        check("stop_state", 32'(dbg_state), 32'd0);
        check("stop_fx1", 32'(fx1), 32'd0);
        en = 1'b1;
        wait_pef("restart_pef");
        repeat (3) @(negedge sys_clk);
        en = 1'b0;
        repeat (2) @(negedge sys_clk);
        en = 1'b1;
        repeat (3) @(negedge sys_clk);
        check("nogap_pef", 32'(period_end_flag), 32'd1);
        check("nogap_state", 32'(dbg_state), 32'd1);

        // reset at cnt=5
        repeat (5) @(negedge sys_clk);
        #1 rst_n = 1'b0;
        #1;
        check("arst_fx1", 32'(fx1), 32'd0);
        check("arst_fx2", 32'(fx2), 32'd0);
        check("arst_state", 32'(dbg_state), 32'd0);
        @(negedge sys_clk);
        #1 rst_n = 1'b1;
        repeat (6) @(negedge sys_clk);
        check("post_rst_idle", 32'(dbg_state), 32'd0);

        // randomized traffic
        for (int c = 0; c < 4000; c++) begin
            @(negedge sys_clk);
            if (!rst_n) begin
                #1 rst_n = 1'b1;
            end else if ($urandom_range(0, 599) == 0) begin
                #1 rst_n = 1'b0;
            end
            en        = ($urandom_range(0, 15) != 0);
            cfg_valid = ($urandom_range(0, 5) == 0);
            cfg_period = W'($urandom_range(0, 20));
            cfg_shift  = W'($urandom_range(0, int'(cfg_period) + 1));
        end
        cfg_valid = 1'b0;
        repeat (2) @(negedge sys_clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/phase_gen.md
PHASE_GEN -- requirements
Module: phase_gen

Interface
REQ-001 Parameter: W, 16, width of period/shift config and counters.
REQ-002 Port: sys_clk  input  1  sole clock, rising edge.
REQ-003 Port: rst_n  input  1  asynchronous active-low reset.
REQ-004 Port: en  input  1  run request; level-sensitive.
REQ-005 Port: cfg_valid  input  1  config offer.
REQ-006 Port: cfg_ready  output  1  config accept capability.
REQ-007 Port: cfg_period  input  W  period in sys_clk cycles.
REQ-008 Port: cfg_shift  input  W  fx2 lag behind fx1 in sys_clk cycles.
REQ-009 Port: fx1  output  1  reference square wave.
REQ-010 Port: fx2  output  1  phase-shifted square wave.
REQ-011 Port: period_end_flag  output  1  one-cycle pulse per completed period.
REQ-012 Port: cfg_err  output  1  one-cycle pulse on rejected config.

Function
REQ-013 Config transfer SHALL occur on a rising edge with cfg_valid=1 and cfg_ready=1.
REQ-014 Accepted config with cfg_period<2 or cfg_shift>=cfg_period SHALL be discarded, with cfg_err=1 for exactly the following cycle.
REQ-015 A legal config SHALL be written to a shadow register; cfg_ready SHALL be 0 while the shadow holds an unapplied config.
REQ-016 In IDLE, the shadow SHALL apply to the active config on the cycle after acceptance; in RUN, only at the counter wrap (cnt==period_act-1).
REQ-017 FSM states: IDLE, RUN; IDLE->RUN when en=1 and an active config exists; RUN->IDLE at counter wrap when en=0.
REQ-018 Deasserting en mid-period SHALL complete the current period; re-asserting en before the wrap SHALL keep RUN without a gap.
REQ-019 In RUN, cnt SHALL start at 0, increment by 1 per cycle, and wrap from period_act-1 to 0.
REQ-020 half = period_act>>1; fx1 SHALL be registered (cnt<half), so odd periods yield a high time of floor(P/2).
REQ-021 d = cnt-shift_act if cnt>=shift_act, else cnt+period_act-shift_act, computed in W+1 bits; fx2 SHALL be registered (d<half).
REQ-022 fx1/fx2 SHALL lag cnt by exactly 1 cycle; period_end_flag SHALL be 1 the cycle after cnt==period_act-1.
REQ-023 In IDLE, fx1, fx2 and period_end_flag SHALL be 0 and cnt SHALL be 0.
REQ-024 If a wrap and a config acceptance occur on the same edge, the new config SHALL go to the shadow and SHALL apply at the next wrap.

Reset
REQ-025 While rst_n=0, the block SHALL be in state IDLE and SHALL hold cnt=0, fx1=0, fx2=0, period_end_flag=0, cfg_err=0, cfg_ready=1, with active and shadow configs invalid.
REQ-026 Reset mid-period SHALL abort immediately; a new config SHALL be required before RUN.

Configuration
REQ-027 With PHASE_GEN_CNT_EN defined, the block SHALL add output period_cnt (W bits, reset 0), incremented with each period_end_flag pulse and saturating at all-ones.
REQ-028 With PHASE_GEN_CNT_EN undefined, period_cnt SHALL be absent and behaviour SHALL otherwise be identical.

Structure
REQ-029 A shared package phase_pkg SHALL hold the FSM state enum, the default W, and the minimum period constant (2).
REQ-030 Sub-module phase_gen_cfg SHALL contain the handshake, legality check, shadow and active registers; the counter, FSM and wave generation SHALL stay in the top level.

Verification
REQ-031 Scenario: period=8, shift=2, en=1 -> fx1 pattern 11110000 repeating; fx2 = fx1 delayed 2 cycles; period_end_flag every 8 cycles.
REQ-032 Scenario: period=7, shift=0 -> fx1 high 3 cycles, low 4; fx2==fx1 every cycle.
REQ-033 Scenario: cfg_period=1, and separately cfg_period=10 with cfg_shift=10 -> cfg_err one pulse each; outputs and active config unchanged.
REQ-034 Scenario: while running period=8, load period=12, shift=3 mid-period -> cfg_ready=0 until wrap; old period completes; next period is 12 with a 3-cycle lag; cfg_ready returns to 1.
REQ-035 Scenario: en dropped at cnt=3 of period=8 -> 4 more cycles run, period_end_flag pulses, then IDLE with fx1=fx2=0; en re-raised at cnt=5 -> no gap.
REQ-036 Scenario: rst_n pulsed low at cnt=5 -> all outputs 0 immediately; en=1 without new config stays IDLE; with PHASE_GEN_CNT_EN defined, period_cnt returns to 0.
